// File: rtl/rock_pkg.sv
// Shared state encoding, default timing and small helpers for the rocking controller.
package rock_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        EVAL   = 3'd2,
        HOLD   = 3'd3,
        NEXT   = 3'd4,
        DONE   = 3'd5,
        FAULT  = 3'd6
    } rock_state_e;

    localparam int unsigned DEF_NUM_SETTINGS = 8;
    localparam int unsigned DEF_IDX_W        = 3;
    localparam int unsigned DEF_CNT_W        = 8;
    localparam int unsigned DEF_SETTLE_TICKS = 8;
    localparam int unsigned DEF_EVAL_TICKS   = 16;
    localparam int unsigned DEF_HOLD_TICKS   = 32;
    localparam int unsigned DEF_CALM_EVALS   = 3;
    localparam int unsigned DEF_MAX_PASSES   = 2;

    // States in which the cradle motor is driven and the session counts as busy.
    function automatic logic is_active(input rock_state_e st);
        return (st == SETTLE) || (st == EVAL) || (st == HOLD) || (st == NEXT);
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Tick-gated interval timer; expire marks the tick on which the count reaches limit-1.
module tick_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             tick,
    input  logic [CNT_W-1:0] limit,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    // Combinational so the FSM can act on the closing tick in the same cycle.
    assign expire = tick && (cnt == (limit - CNT_W'(1)));

    // Count ticks; load restarts the interval on every state entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= expire ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rock_controller.sv
// Steps the cradle motor through rocking settings and judges each from stress verdicts.
module rock_controller
    import rock_pkg::*;
#(
    parameter int unsigned NUM_SETTINGS = DEF_NUM_SETTINGS,
    parameter int unsigned IDX_W        = DEF_IDX_W,
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter int unsigned SETTLE_TICKS = DEF_SETTLE_TICKS,
    parameter int unsigned EVAL_TICKS   = DEF_EVAL_TICKS,
    parameter int unsigned HOLD_TICKS   = DEF_HOLD_TICKS,
    parameter int unsigned CALM_EVALS   = DEF_CALM_EVALS,
    parameter int unsigned MAX_PASSES   = DEF_MAX_PASSES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic               stop,
    input  logic               clr_fault,
    input  logic               gedaald,
    input  logic               gelijk,
    input  logic               error,
    output logic [IDX_W-1:0]   setting,
    output logic               motor_en,
    output logic               eval_req,
    output logic               busy,
    output logic               done,
    output logic               fault,
    output logic [STATE_W-1:0] state_dbg
);

    localparam int unsigned CALM_W = $clog2(CALM_EVALS + 1);
    localparam int unsigned PASS_W = $clog2(MAX_PASSES + 1);

    rock_state_e       state, state_nxt;
    logic [IDX_W-1:0]  setting_nxt;
    logic [CALM_W-1:0] calm_cnt, calm_nxt, calm_inc_c;
    logic [PASS_W-1:0] pass_cnt, pass_nxt, pass_inc_c;
    logic              settled, settled_nxt;
    logic              eval_req_nxt;
    logic              load_c;
    logic [CNT_W-1:0]  limit_c;
    logic              timer_expire;

    assign calm_inc_c = calm_cnt + CALM_W'(1);
    assign pass_inc_c = pass_cnt + PASS_W'(1);

    // Every state change restarts the interval timer.
    assign load_c = (state_nxt != state);

    // Interval length for the state currently being timed.
    always_comb begin
        limit_c = CNT_W'(SETTLE_TICKS);
        case (state)
            EVAL:    limit_c = CNT_W'(EVAL_TICKS);
            HOLD:    limit_c = CNT_W'(HOLD_TICKS);
            default: limit_c = CNT_W'(SETTLE_TICKS);
        endcase
    end

    tick_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (load_c),
        .tick   (tick),
        .limit  (limit_c),
        .expire (timer_expire)
    );

    // Next-state and next-value logic; stop overrides everything except FAULT.
    always_comb begin
        state_nxt    = state;
        setting_nxt  = setting;
        calm_nxt     = calm_cnt;
        pass_nxt     = pass_cnt;
        settled_nxt  = settled;
        eval_req_nxt = 1'b0;

        if (stop && (state != FAULT)) begin
            state_nxt   = IDLE;
            setting_nxt = '0;
            calm_nxt    = '0;
            pass_nxt    = '0;
            settled_nxt = 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_nxt   = SETTLE;
                        setting_nxt = '0;
                        calm_nxt    = '0;
                        pass_nxt    = '0;
                        settled_nxt = 1'b0;
                    end
                end
                SETTLE, HOLD: begin
                    if (timer_expire) begin
                        state_nxt    = EVAL;
                        eval_req_nxt = 1'b1;
                    end
                end
                EVAL: begin
                    if (timer_expire) begin
                        if (error) begin
                            state_nxt = FAULT;
                        end else if (gedaald) begin
                            state_nxt   = HOLD;
                            settled_nxt = 1'b1;
                            calm_nxt    = '0;
                        end else if (gelijk && settled) begin
                            calm_nxt  = calm_inc_c;
                            state_nxt = (calm_inc_c == CALM_W'(CALM_EVALS)) ? DONE : HOLD;
                        end else begin
                            state_nxt   = NEXT;
                            settled_nxt = 1'b0;
                            calm_nxt    = '0;
                        end
                    end
                end
                NEXT: begin
                    if (setting == IDX_W'(NUM_SETTINGS - 1)) begin
                        setting_nxt = '0;
                        pass_nxt    = pass_inc_c;
                        state_nxt   = (pass_inc_c == PASS_W'(MAX_PASSES)) ? FAULT : SETTLE;
                    end else begin
                        setting_nxt = setting + IDX_W'(1);
                        state_nxt   = SETTLE;
                    end
                end
                FAULT: begin
                    if (clr_fault) begin
                        state_nxt   = IDLE;
                        setting_nxt = '0;
                        calm_nxt    = '0;
                        pass_nxt    = '0;
                        settled_nxt = 1'b0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State register and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            setting  <= '0;
            calm_cnt <= '0;
            pass_cnt <= '0;
            settled  <= 1'b0;
            eval_req <= 1'b0;
            motor_en <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state    <= state_nxt;
            setting  <= setting_nxt;
            calm_cnt <= calm_nxt;
            pass_cnt <= pass_nxt;
            settled  <= settled_nxt;
            eval_req <= eval_req_nxt;
            motor_en <= is_active(state_nxt);
            busy     <= is_active(state_nxt);
            done     <= (state_nxt == DONE);
            fault    <= (state_nxt == FAULT);
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_rock_controller.sv
// Directed bench for rock_controller with hand-computed cycle timelines (tick every cycle unless noted).
module tb_rock_controller;
    import rock_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clr_fault = 1'b0;
    logic       gedaald = 1'b0;
    logic       gelijk = 1'b0;
    logic       error = 1'b0;
    logic [2:0] setting;
    logic       motor_en;
    logic       eval_req;
    logic       busy;
    logic       done;
    logic       fault;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    rock_controller dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .start     (start),
        .stop      (stop),
        .clr_fault (clr_fault),
        .gedaald   (gedaald),
        .gelijk    (gelijk),
        .error     (error),
        .setting   (setting),
        .motor_en  (motor_en),
        .eval_req  (eval_req),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic expect_st(input string tag, input rock_state_e st, input int set, input logic mot);
        check({tag, ".state"},   32'(state_dbg), 32'(st));
        check({tag, ".setting"}, 32'(setting),   32'(set));
        check({tag, ".motor"},   32'(motor_en),  32'(mot));
    endtask

    // start sampled on one edge (E0); state is SETTLE right after it.
    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    initial begin
        tick = 1'b1;
        run(3);
        expect_st("rst", IDLE, 0, 1'b0);
        check("rst.busy",  32'(busy),  0);
        check("rst.done",  32'(done),  0);
        check("rst.fault", 32'(fault), 0);
        reset = 1'b0;
        step();

        // 1: flat stress without a settled setting steps the table; reset from HOLD at setting 5.
        gelijk = 1'b1;
        do_start();
        expect_st("t1.e0", SETTLE, 0, 1'b1);
        run(24);
        expect_st("t1.next0", NEXT, 0, 1'b1);
        step();
        expect_st("t1.set1", SETTLE, 1, 1'b1);
        run(100);
        expect_st("t1.set5", SETTLE, 5, 1'b1);
        run(8);
        check("t1.evalreq", 32'(eval_req), 1);
        gedaald = 1'b1;
        run(16);
        expect_st("t1.hold5", HOLD, 5, 1'b1);
        gedaald = 1'b0;
        gelijk  = 1'b0;
        reset   = 1'b1;
        step();
        reset   = 1'b0;
        expect_st("t1.reset", IDLE, 0, 1'b0);
        check("t1.fault", 32'(fault), 0);
        check("t1.done",  32'(done),  0);
        check("t1.busy",  32'(busy),  0);

        // 2: falling stress holds setting 0; eval_req 8 cycles after start, one cycle wide.
        gedaald = 1'b1;
        do_start();
        run(7);
        expect_st("t2.e7", SETTLE, 0, 1'b1);
        check("t2.e7.req", 32'(eval_req), 0);
        step();
        expect_st("t2.e8", EVAL, 0, 1'b1);
        check("t2.e8.req", 32'(eval_req), 1);
        step();
        check("t2.e9.req", 32'(eval_req), 0);
        run(15);
        expect_st("t2.hold", HOLD, 0, 1'b1);
        run(32);
        expect_st("t2.reeval", EVAL, 0, 1'b1);
        check("t2.reeval.req", 32'(eval_req), 1);
        run(16);
        expect_st("t2.hold2", HOLD, 0, 1'b1);
        gedaald = 1'b0;
        do_stop();
        expect_st("t2.stop", IDLE, 0, 1'b0);

        // 3: gedaald then three gelijk verdicts reach DONE.
        gedaald = 1'b1;
        do_start();
        run(24);
        expect_st("t3.hold", HOLD, 0, 1'b1);
        gedaald = 1'b0;
        gelijk  = 1'b1;
        run(48);
        expect_st("t3.calm1", HOLD, 0, 1'b1);
        run(48);
        expect_st("t3.calm2", HOLD, 0, 1'b1);
        run(47);
        expect_st("t3.last", EVAL, 0, 1'b1);
        check("t3.last.done", 32'(done), 0);
        step();
        expect_st("t3.done", DONE, 0, 1'b0);
        check("t3.done.done", 32'(done), 1);
        check("t3.done.busy", 32'(busy), 0);
        gelijk = 1'b0;
        run(5);
        check("t3.stay.done", 32'(done), 1);
        do_start();
        expect_st("t3.restart", SETTLE, 0, 1'b1);
        check("t3.restart.done", 32'(done), 0);
        do_stop();

        // 4: no verdicts: two full passes then FAULT; clr_fault returns to IDLE.
        do_start();
        run(199);
        expect_st("t4.next7a", NEXT, 7, 1'b1);
        step();
        expect_st("t4.wrap1", SETTLE, 0, 1'b1);
        run(199);
        expect_st("t4.next7b", NEXT, 7, 1'b1);
        step();
        expect_st("t4.fault", FAULT, 0, 1'b0);
        check("t4.fault.flag", 32'(fault), 1);
        check("t4.fault.busy", 32'(busy),  0);
        clr_fault = 1'b1;
        step();
        clr_fault = 1'b0;
        expect_st("t4.clr", IDLE, 0, 1'b0);
        check("t4.clr.fault", 32'(fault), 0);

        // 5: error ignored in SETTLE, taken at EVAL close; FAULT ignores start/stop.
        error = 1'b1;
        do_start();
        run(8);
        expect_st("t5.eval", EVAL, 0, 1'b1);
        run(16);
        expect_st("t5.fault", FAULT, 0, 1'b0);
        error = 1'b0;
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        run(3);
        expect_st("t5.sticky", FAULT, 0, 1'b0);
        check("t5.sticky.flag", 32'(fault), 1);
        clr_fault = 1'b1;
        step();
        clr_fault = 1'b0;
        expect_st("t5.clr", IDLE, 0, 1'b0);

        // 6: tick gating, stop over start, stop over a closing verdict.
        do_start();
        run(3);
        tick = 1'b0;
        run(20);
        expect_st("t6.gated", SETTLE, 0, 1'b1);
        tick = 1'b1;
        run(4);
        expect_st("t6.cnt7", SETTLE, 0, 1'b1);
        step();
        expect_st("t6.eval", EVAL, 0, 1'b1);
        check("t6.eval.req", 32'(eval_req), 1);
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        expect_st("t6.stopwins", IDLE, 0, 1'b0);
        check("t6.stopwins.busy", 32'(busy), 0);
        do_start();
        expect_st("t6.restart", SETTLE, 0, 1'b1);
        error = 1'b1;
        run(23);
        expect_st("t6.closing", EVAL, 0, 1'b1);
        do_stop();
        error = 1'b0;
        expect_st("t6.stopverdict", IDLE, 0, 1'b0);
        check("t6.stopverdict.fault", 32'(fault), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
